imem_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 19 +
 rtl/imem_ram.sv | 30 +++
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e      : loader FSM state encoding
//   TEXT_BASE_DEFAULT : byte address of instruction word 0 (core reset PC)
//   NOP_INST          : instruction returned whenever a fetch is not served
package boot_pkg;

   typedef enum logic [2:0] {
      ST_HDR0  = 3'd0,
      ST_HDR1  = 3'd1,
      ST_DATA  = 3'd2,
      ST_CKSUM = 3'd3,
      ST_RUN   = 3'd4,
      ST_ERROR = 3'd5
   } boot_state_e;

   localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP_INST          = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: DEPTH_WORDS x 32, no reset on contents.
//   clk   in  : write clock
//   we    in  : write enable
//   waddr in  : write word index
//   wdata in  : write data
//   raddr in  : read word index
//   rdata out : read data, asynchronous
module imem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader / instruction front end for the single-cycle core.
// Receives a little-endian image over a byte stream (16-bit word count N,
// then N 32-bit words, then an optional XOR checksum byte), writes it into
// instruction memory while holding the core in reset, then releases the
// core and serves im_inst combinationally from pc.
//
// Optional feature macro: BOOT_CKSUM_EN (trailing checksum byte + CKSUM state).
//
// Ports:
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset
//   rx_data   in  : image byte
//   rx_valid  in  : rx_data valid
//   rx_ready  out : loader accepts a byte this cycle
//   pc        in  : core program counter
//   im_inst   out : instruction at pc (combinational)
//   cpu_rst   out : active-high core reset
//   cpu_ena   out : core register-file enable
//   load_done out : image loaded, core running
//   load_err  out : image rejected (sticky until reset)
//
// state    | meaning
// ---------+------------------------------------------------
// ST_HDR0  | waiting for word count low byte
// ST_HDR1  | waiting for word count high byte, range check
// ST_DATA  | receiving payload words, writing memory
// ST_CKSUM | waiting for XOR checksum byte (BOOT_CKSUM_EN)
// ST_RUN   | image loaded, core released, fetches served
// ST_ERROR | image rejected, core held in reset
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] TEXT_BASE   = TEXT_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [31:0] pc,
   output logic [31:0] im_inst,
   output logic        cpu_rst,
   output logic        cpu_ena,
   output logic        load_done,
   output logic        load_err
);

`ifdef BOOT_CKSUM_EN
   localparam boot_state_e ST_AFTER_DATA = ST_CKSUM;
`else
   localparam boot_state_e ST_AFTER_DATA = ST_RUN;
`endif

   boot_state_e       state_q, state_d;
   logic [15:0]       n_q;
   logic [ADDR_W-1:0] w_q;
   logic [1:0]        b_q;
   logic [23:0]       asm_q;
`ifdef BOOT_CKSUM_EN
   logic [7:0]        xor_q;
`endif

   logic        rx_fire;
   logic [15:0] hdr_n;
   logic        last_word;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] fetch_idx;
   logic        fetch_ok;

   assign rx_fire   = rx_valid && rx_ready;
   assign hdr_n     = {rx_data, n_q[7:0]};
   assign last_word = (16'(w_q) == (n_q - 16'd1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR0: begin
            if (rx_fire) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            if (rx_fire) begin
               if (32'(hdr_n) > 32'(DEPTH_WORDS)) state_d = ST_ERROR;
               else if (hdr_n == 16'd0)            state_d = ST_AFTER_DATA;
               else                                state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_fire && (b_q == 2'd3) && last_word) state_d = ST_AFTER_DATA;
         end
`ifdef BOOT_CKSUM_EN
         ST_CKSUM: begin
            if (rx_fire) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERROR;
         end
`endif
         ST_RUN:   state_d = ST_RUN;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_HDR0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HDR0;
         n_q     <= 16'd0;
         w_q     <= '0;
         b_q     <= 2'd0;
         asm_q   <= 24'd0;
`ifdef BOOT_CKSUM_EN
         xor_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         if (rx_fire) begin
            case (state_q)
               ST_HDR0: n_q[7:0]  <= rx_data;
               ST_HDR1: n_q[15:8] <= rx_data;
               ST_DATA: begin
                  // Little-endian: newest byte enters at the top, so after
                  // three bytes asm_q holds bits [23:0] of the word.
                  asm_q <= {rx_data, asm_q[23:8]};
                  b_q   <= b_q + 2'd1;
                  if (b_q == 2'd3) w_q <= w_q + 1'b1;
`ifdef BOOT_CKSUM_EN
                  xor_q <= xor_q ^ rx_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_we = rx_fire && (state_q == ST_DATA) && (b_q == 2'd3);

   // Word index relative to TEXT_BASE; upper bits take part in the range
   // check so addresses far above the image never alias into it.
   assign fetch_idx = (pc - TEXT_BASE) >> 2;
   assign fetch_ok  = (state_q == ST_RUN) && (pc[1:0] == 2'b00) &&
                      (pc >= TEXT_BASE) && (fetch_idx < 32'(n_q));

   imem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_imem_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (w_q),
      .wdata ({rx_data, asm_q}),
      .raddr (fetch_idx[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   assign im_inst   = fetch_ok ? mem_rdata : NOP_INST;

   assign rx_ready  = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                      (state_q == ST_DATA) || (state_q == ST_CKSUM);
   assign cpu_rst   = (state_q != ST_RUN);
   assign cpu_ena   = (state_q == ST_RUN);
   assign load_done = (state_q == ST_RUN);
   assign load_err  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
   import boot_pkg::*;

   localparam int          DEPTH   = 1024;
   localparam int          AW      = 10;
   localparam logic [31:0] TB_BASE = 32'h0040_0000;
`ifdef BOOT_CKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] pc;
   logic [31:0] im_inst;
   logic        cpu_rst;
   logic        cpu_ena;
   logic        load_done;
   logic        load_err;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (AW),
      .TEXT_BASE   (TB_BASE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .pc        (pc),
      .im_inst   (im_inst),
      .cpu_rst   (cpu_rst),
      .cpu_ena   (cpu_ena),
      .load_done (load_done),
      .load_err  (load_err)
   );

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: loaded words, count, outcome
   logic [31:0] m_mem [DEPTH];
   int          m_n;
   bit          m_run;
   bit          m_err;
   int          nx_n;
   bit          nx_run;
   bit          nx_err;
   logic [31:0] wq [$];
   logic [7:0]  img [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_inst(input logic [31:0] p);
      longint off;
      if (!m_run)         return 32'h0;
      if (p[1:0] != 2'b0) return 32'h0;
      if (p < TB_BASE)    return 32'h0;
      off = (longint'(p) - longint'(TB_BASE)) / 4;
      if (off >= longint'(m_n)) return 32'h0;
      return m_mem[int'(off)];
   endfunction

   task automatic check_status(input string tag);
      check({tag, ":load_done"}, 32'(load_done), 32'(m_run));
      check({tag, ":cpu_ena"},   32'(cpu_ena),   32'(m_run));
      check({tag, ":cpu_rst"},   32'(cpu_rst),   32'(!m_run));
      check({tag, ":load_err"},  32'(load_err),  32'(m_err));
      check({tag, ":rx_ready"},  32'(rx_ready),  32'(!(m_run || m_err)));
   endtask

   task automatic probe(input string tag, input logic [31:0] p);
      pc = p;
      #1;
      check({tag, ":im_inst"}, im_inst, exp_inst(p));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      m_run = 0; m_err = 0; m_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Builds img from count n and words in wq; computes the expected outcome.
   task automatic build(input int n, input bit bad_ck);
      logic [7:0] x;
      logic [7:0] b;
      logic [15:0] n16;
      n16 = 16'(n);
      x = 8'h00;
      img.delete();
      img.push_back(n16[7:0]);
      img.push_back(n16[15:8]);
      for (int i = 0; i < wq.size(); i++) begin
         for (int k = 0; k < 4; k++) begin
            b = wq[i][8*k +: 8];
            img.push_back(b);
            x ^= b;
         end
      end
      if (CK_EN && n <= DEPTH) img.push_back(bad_ck ? (x ^ 8'h01) : x);
      nx_n   = n;
      nx_err = (n > DEPTH) || (CK_EN && bad_ck);
      nx_run = !nx_err;
   endtask

   task automatic commit();
      m_n   = nx_n;
      m_run = nx_run;
      m_err = nx_err;
      for (int i = 0; i < wq.size(); i++) m_mem[i] = wq[i];
   endtask

   task automatic send_img(input int max_gap);
      for (int i = 0; i < img.size(); i++) send_byte(img[i], $urandom_range(0, max_gap));
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{"w0",        32'h0040_0000, 32'h1234_5678};
      vecs[1] = '{"w1",        32'h0040_0004, 32'hDEAD_BEEF};
      vecs[2] = '{"w2_beyond", 32'h0040_0008, 32'h0000_0000};
      vecs[3] = '{"misalign",  32'h0040_0002, 32'h0000_0000};
      vecs[4] = '{"below",     32'h003F_FFFC, 32'h0000_0000};
      vecs[5] = '{"zero_pc",   32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{"far_above", 32'h0040_1000, 32'h0000_0000};

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = TB_BASE;
      m_run = 0; m_err = 0; m_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      #1;
      check_status("reset");
      check("reset:im_inst", im_inst, 32'h0);

      // example image; cpu_rst must fall on the final-byte edge
      wq.delete(); wq.push_back(32'h1234_5678); wq.push_back(32'hDEAD_BEEF);
      build(2, 0);
      for (int i = 0; i < img.size() - 1; i++) send_byte(img[i], 0);
      check("ex2:cpu_rst_before_last", 32'(cpu_rst), 32'h1);
      pc = TB_BASE; #1;
      check("ex2:im_inst_during_load", im_inst, 32'h0);
      send_byte(img[img.size()-1], 0);
      commit();
      check_status("ex2");
      foreach (vecs[i]) begin
         pc = vecs[i].pc;
         #1;
         check({"ex2:", vecs[i].name}, im_inst, vecs[i].inst);
      end
      send_byte(8'hAA, 0);
      check_status("ex2_ignored");
      probe("ex2_ignored", TB_BASE);

      // header count above depth
      do_reset();
      wq.delete();
      build(DEPTH + 1, 0);
      send_byte(img[0], 0);
      check("hdr_err:ready_after_b0", 32'(rx_ready), 32'h1);
      check("hdr_err:err_after_b0",   32'(load_err), 32'h0);
      send_byte(img[1], 0);
      commit();
      check_status("hdr_err");
      probe("hdr_err", TB_BASE);

      // same example image with 3-cycle gaps
      do_reset();
      wq.delete(); wq.push_back(32'h1234_5678); wq.push_back(32'hDEAD_BEEF);
      build(2, 0);
      for (int i = 0; i < img.size(); i++) send_byte(img[i], 3);
      commit();
      check_status("gap");
      probe("gap_w0", TB_BASE);
      probe("gap_w1", TB_BASE + 32'd4);
      probe("gap_w2", TB_BASE + 32'd8);

      // reset mid-load, then a 1-word image
      do_reset();
      for (int i = 0; i < 7; i++) send_byte(img[i], 0);
      rst_n = 1'b0;
      m_run = 0; m_err = 0; m_n = 0;
      #1;
      check_status("midrst");
      probe("midrst", TB_BASE);
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete(); wq.push_back(32'h2000_0013);
      build(1, 0);
      send_img(0);
      commit();
      check_status("after_rst");
      check("after_rst:w0_const", exp_inst(TB_BASE), 32'h2000_0013);
      probe("after_rst_w0", TB_BASE);
      probe("after_rst_w1_hidden", TB_BASE + 32'd4);

      // empty image: stale memory stays hidden
      do_reset();
      wq.delete();
      build(0, 0);
      send_img(1);
      commit();
      check_status("empty");
      probe("empty_w0", TB_BASE);

      if (CK_EN) begin
         do_reset();
         wq.delete(); wq.push_back(32'h0403_0201);
         build(1, 0);
         send_img(0);
         commit();
         check_status("ck_good");
         probe("ck_good_w0", TB_BASE);
         do_reset();
         build(1, 1);
         send_img(0);
         commit();
         check_status("ck_bad");
         probe("ck_bad_w0", TB_BASE);
      end

      // randomized images against the model
      for (int r = 0; r < 6; r++) begin
         int n;
         logic [31:0] p;
         do_reset();
         n = $urandom_range(1, 24);
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         build(n, ($urandom_range(0, 3) == 0));
         send_img(2);
         commit();
         check_status($sformatf("rnd%0d", r));
         for (int k = 0; k < 10; k++) begin
            p = TB_BASE + 32'($urandom_range(0, n + 2)) * 32'd4;
            if ($urandom_range(0, 4) == 0) p = p + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) p = TB_BASE - 32'($urandom_range(1, 64));
            probe($sformatf("rnd%0d_%0d", r, k), p);
         end
      end

      // full-depth image: last index visible, one past it is not
      do_reset();
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
      build(DEPTH, 0);
      send_img(0);
      commit();
      check_status("full");
      probe("full_first", TB_BASE);
      probe("full_last",  TB_BASE + 32'(DEPTH - 1) * 32'd4);
      probe("full_past",  TB_BASE + 32'(DEPTH) * 32'd4);
      for (int k = 0; k < 8; k++)
         probe($sformatf("full_rnd%0d", k), TB_BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
